// File: rtl/clock_calendar_gen_if.sv
// clock_calendar_gen_if: hour feed, date load request and date/strobe outputs of the calendar.
// Weekday signals exist only when CLOCK_CALENDAR_GEN_WEEKDAY_EN is defined.
interface clock_calendar_gen_if #(
    parameter int unsigned YW = 12
);
    logic [5:0]    hour_in;
    logic          load;
    logic [5:0]    day_in;
    logic [4:0]    month_in;
    logic [YW-1:0] year_in;
    logic [5:0]    day_out;
    logic [4:0]    month_out;
    logic [YW-1:0] year_out;
    logic          new_day;
    logic          new_month;
    logic          new_year;
    logic          load_err;
`ifdef CLOCK_CALENDAR_GEN_WEEKDAY_EN
    logic [2:0]    dow_in;
    logic [2:0]    dow_out;

    modport master (
        output hour_in, load, day_in, month_in, year_in, dow_in,
        input  day_out, month_out, year_out, new_day, new_month, new_year, load_err, dow_out
    );
    modport slave (
        input  hour_in, load, day_in, month_in, year_in, dow_in,
        output day_out, month_out, year_out, new_day, new_month, new_year, load_err, dow_out
    );
`else
    modport master (
        output hour_in, load, day_in, month_in, year_in,
        input  day_out, month_out, year_out, new_day, new_month, new_year, load_err
    );
    modport slave (
        input  hour_in, load, day_in, month_in, year_in,
        output day_out, month_out, year_out, new_day, new_month, new_year, load_err
    );
`endif
endinterface

// File: rtl/clock_calendar_gen.sv
// clock_calendar_gen: Gregorian date keeper advanced by the 23 -> 0 hour transition.
// Binary or packed-BCD fields; validated synchronous load; registered rollover strobes.
// Optional weekday counter: define CLOCK_CALENDAR_GEN_WEEKDAY_EN.
module clock_calendar_gen #(
    parameter int unsigned BCD        = 0,
    parameter int unsigned YEARRES    = 12,
    parameter int unsigned YEARDIGITS = 4,
    parameter int unsigned YEAR_BASE  = 0
) (
    input  logic                clk,
    input  logic                rst,
    clock_calendar_gen_if.slave bus
);
    localparam int unsigned YW         = (BCD != 0) ? 4 * YEARDIGITS : YEARRES;
    localparam int unsigned LW         = YW + 12;
    localparam logic [5:0]  HOUR_LAST  = (BCD != 0) ? 6'h23 : 6'd23;
    localparam logic [4:0]  MONTH_LAST = (BCD != 0) ? 5'h12 : 5'd12;

    logic [5:0]    hour_prev;
    logic [5:0]    day_q;
    logic [4:0]    month_q;
    logic [YW-1:0] year_q;
    logic          new_day_q;
    logic          new_month_q;
    logic          new_year_q;
    logic          load_err_q;

    // Divisibility by 4 of a two-digit BCD value, from tens-digit parity and units digit.
    function automatic logic div4_bcd(input logic tens_odd, input logic [3:0] units);
        if (tens_odd)
            return (units == 4'd2) || (units == 4'd6);
        return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    endfunction

    // Full Gregorian leap test in the configured encoding.
    function automatic logic is_leap(input logic [YW-1:0] y);
        logic [15:0]   yb;
        logic [LW-1:0] t;
        yb = 16'(y);
        t  = LW'(y) + LW'(YEAR_BASE);
        if (BCD != 0) begin
            if (yb[7:0] != 8'h00)
                return div4_bcd(yb[4], yb[3:0]);
            if (YEARDIGITS == 4)
                return div4_bcd(yb[12], yb[11:8]);
            return 1'b1;
        end
        return (t[1:0] == 2'b00) && (((t % LW'(100)) != '0) || ((t % LW'(400)) == '0));
    endfunction

    // Month number 1..12 regardless of encoding (valid months only).
    function automatic logic [3:0] month_idx(input logic [4:0] m);
        if ((BCD != 0) && m[4])
            return m[3:0] + 4'd10;
        return m[3:0];
    endfunction

    function automatic logic month_ok(input logic [4:0] m);
        if (BCD != 0) begin
            if (m[4])
                return m[3:0] <= 4'd2;
            return (m[3:0] != 4'd0) && (m[3:0] <= 4'd9);
        end
        return (m != 5'd0) && (m <= 5'd12);
    endfunction

    // Month length, returned in the configured encoding.
    function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic leap);
        logic [4:0] n;
        case (month_idx(m))
            4'd2:                     n = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: n = 5'd30;
            default:                  n = 5'd31;
        endcase
        if (BCD != 0)
            return {2'(n / 5'd10), 4'(n % 5'd10)};
        return {1'b0, n};
    endfunction

    // Day/month increment; BCD carries x9 -> (x+1)0.
    function automatic logic [5:0] inc_field(input logic [5:0] v);
        if ((BCD != 0) && (v[3:0] == 4'd9))
            return {v[5:4] + 2'd1, 4'd0};
        return v + 6'd1;
    endfunction

    // Year increment; BCD ripples a decimal carry so all-9s wraps to all-0s.
    function automatic logic [YW-1:0] inc_year(input logic [YW-1:0] y);
        logic [YW-1:0] r;
        logic          carry;
        r     = y;
        carry = 1'b1;
        if (BCD == 0)
            return y + YW'(1);
        for (int i = 0; i < int'(YW / 4); i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic year_digits_ok(input logic [YW-1:0] y);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(YW / 4); i++)
            if (y[4*i +: 4] > 4'd9)
                ok = 1'b0;
        return ok;
    endfunction

    logic       roll_c;
    logic       day_wrap_c;
    logic       month_wrap_c;
    logic       load_ok_c;
    logic [5:0] dim_load_c;

    assign roll_c       = (hour_prev == HOUR_LAST) && (bus.hour_in == 6'd0);
    assign day_wrap_c   = (day_q == days_in_month(month_q, is_leap(year_q)));
    assign month_wrap_c = (month_q == MONTH_LAST);
    assign dim_load_c   = days_in_month(bus.month_in, is_leap(bus.year_in));

    // Load validation: month range, day against month length of the loaded year, BCD digits.
    always_comb begin
        load_ok_c = month_ok(bus.month_in) && (bus.day_in != 6'd0) && (bus.day_in <= dim_load_c);
        if (BCD != 0)
            load_ok_c = load_ok_c && (bus.day_in[3:0] <= 4'd9) && year_digits_ok(bus.year_in);
`ifdef CLOCK_CALENDAR_GEN_WEEKDAY_EN
        load_ok_c = load_ok_c && (bus.dow_in <= 3'd6);
`endif
    end

    // Date registers: load beats roll; roll carries day -> month -> year in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_prev   <= 6'd0;
            day_q       <= 6'd1;
            month_q     <= 5'd1;
            year_q      <= '0;
            new_day_q   <= 1'b0;
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hour_prev   <= bus.hour_in;
            new_day_q   <= 1'b0;
            new_month_q <= 1'b0;
            new_year_q  <= 1'b0;
            load_err_q  <= 1'b0;
            if (bus.load) begin
                if (load_ok_c) begin
                    day_q   <= bus.day_in;
                    month_q <= bus.month_in;
                    year_q  <= bus.year_in;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (roll_c) begin
                new_day_q <= 1'b1;
                if (day_wrap_c) begin
                    day_q       <= 6'd1;
                    new_month_q <= 1'b1;
                    if (month_wrap_c) begin
                        month_q    <= 5'd1;
                        year_q     <= inc_year(year_q);
                        new_year_q <= 1'b1;
                    end else begin
                        month_q <= 5'(inc_field({1'b0, month_q}));
                    end
                end else begin
                    day_q <= inc_field(day_q);
                end
            end
        end
    end

`ifdef CLOCK_CALENDAR_GEN_WEEKDAY_EN
    logic [2:0] dow_q;

    // Weekday: loaded with the date, advances modulo 7 on every roll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dow_q <= 3'd0;
        end else if (bus.load) begin
            if (load_ok_c)
                dow_q <= bus.dow_in;
        end else if (roll_c) begin
            dow_q <= (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
        end
    end

    assign bus.dow_out = dow_q;
`endif

    assign bus.day_out   = day_q;
    assign bus.month_out = month_q;
    assign bus.year_out  = year_q;
    assign bus.new_day   = new_day_q;
    assign bus.new_month = new_month_q;
    assign bus.new_year  = new_year_q;
    assign bus.load_err  = load_err_q;

endmodule
